// File: rtl/bcd_up_down_counter_pkg.sv
// Shared BCD constants and helpers for the counter
// and the Excess-3 converter test bench.
package bcd_up_down_counter_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'b1001;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'b0000;

  function automatic logic bcd_digit_valid(
    input logic [DIGIT_W-1:0] d
  );
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_up_down_counter_digit_cell.sv
// One BCD digit register with clear, load and
// direction-aware single-step.
module bcd_digit_cell
  import bcd_up_down_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               step,
  input  logic               up_dn,
  output logic [DIGIT_W-1:0] digit,
  output logic               term_up,
  output logic               term_dn
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Next digit; out-of-range digits recover to the wrap value.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = load_val;
    end else if (step) begin
      if (up_dn) begin
        if (digit_q < BCD_MAX) digit_d = digit_q + 4'd1;
        else                   digit_d = BCD_MIN;
      end else begin
        if (digit_q == BCD_MIN || digit_q > BCD_MAX)
          digit_d = BCD_MAX;
        else
          digit_d = digit_q - 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= BCD_MIN;
    else        digit_q <= digit_d;
  end

  assign digit   = digit_q;
  assign term_up = (digit_q == BCD_MAX);
  assign term_dn = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_up_down_counter.sv
// Multi-digit BCD up/down counter with validated
// parallel load and a cascade terminal count.
module bcd_up_down_counter
  import bcd_up_down_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      en,
  input  logic                      up_dn,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      tc,
  output logic                      load_err
);

  logic              load_ok;
  logic              load_acc;
  logic              cnt_en;
  logic              load_err_q;
  logic              load_err_d;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] term_up;
  logic [DIGITS-1:0] term_dn;

  // A load is accepted only if every digit is legal BCD.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(load_val[DIGIT_W*i +: DIGIT_W]))
        load_ok = 1'b0;
    end
  end

  assign load_acc = load & ~clr & load_ok;
  // Any load, rejected or not, blocks counting.
  assign cnt_en   = en & ~clr & ~load;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      assign term[g] = up_dn ? term_up[g] : term_dn[g];

      if (g == 0) begin : g_lsd
        assign step[g] = cnt_en;
      end else begin : g_hi
        assign step[g] = step[g-1] & term[g-1];
      end

      bcd_digit_cell u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load_acc),
        .load_val (load_val[DIGIT_W*g +: DIGIT_W]),
        .step     (step[g]),
        .up_dn    (up_dn),
        .digit    (bcd[DIGIT_W*g +: DIGIT_W]),
        .term_up  (term_up[g]),
        .term_dn  (term_dn[g])
      );
    end
  endgenerate

  assign tc = en & (&term);

  // Rejected-load flag is a one-cycle pulse.
  always_comb begin
    load_err_d = 1'b0;
    if (!clr && load && !load_ok) load_err_d = 1'b1;
  end

  // Rejected-load flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_err_q <= 1'b0;
    else        load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// Directed self-checking bench for bcd_up_down_counter.
module tb_bcd_up_down_counter;
  import bcd_up_down_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       up_dn;
  logic [7:0] bcd;
  logic       tc;
  logic       load_err;

  int passed = 0;
  int total  = 0;

  bcd_up_down_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up_dn    (up_dn),
    .bcd      (bcd),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    logic [3:0] dg;
    rst_n = 1'b0; clr = 0; load = 0;
    load_val = 8'h00; en = 0; up_dn = 1;
    #12;
    chk("reset_bcd", 32'(bcd), 32'h00);
    chk("reset_err", 32'(load_err), 32'h0);
    rst_n = 1'b1;

    load = 1; load_val = 8'h46;
    tick();
    load = 0; en = 1; up_dn = 1;
    tick();
    chk("pre_rst_47", 32'(bcd), 32'h47);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bcd", 32'(bcd), 32'h00);
    chk("async_rst_err", 32'(load_err), 32'h0);
    tick();
    chk("rst_held", 32'(bcd), 32'h00);
    rst_n = 1'b1; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_zero", 32'(bcd), 32'h00);
    end

    load = 1; load_val = 8'h97;
    tick();
    chk("load_97", 32'(bcd), 32'h97);
    load = 0; en = 1; up_dn = 1;
    #1 chk("tc_97", 32'(tc), 32'h0);
    tick();
    chk("up_98", 32'(bcd), 32'h98);
    chk("tc_98", 32'(tc), 32'h0);
    tick();
    chk("up_99", 32'(bcd), 32'h99);
    chk("tc_99", 32'(tc), 32'h1);
    tick();
    chk("up_wrap_00", 32'(bcd), 32'h00);
    chk("tc_00_up", 32'(tc), 32'h0);

    en = 0; load = 1; load_val = 8'h10;
    tick();
    load = 0; en = 1; up_dn = 0;
    tick();
    chk("dn_09", 32'(bcd), 32'h09);
    chk("tc_09_dn", 32'(tc), 32'h0);
    for (int i = 0; i < 9; i++) tick();
    chk("dn_00", 32'(bcd), 32'h00);
    chk("tc_00_dn", 32'(tc), 32'h1);
    up_dn = 1;
    #1 chk("tc_dir_flip", 32'(tc), 32'h0);
    up_dn = 0;
    tick();
    chk("dn_wrap_99", 32'(bcd), 32'h99);

    en = 0; load = 1; load_val = 8'h25;
    tick();
    load_val = 8'h3A; en = 1; up_dn = 1;
    tick();
    chk("bad_load_hold", 32'(bcd), 32'h25);
    chk("bad_load_err", 32'(load_err), 32'h1);
    load = 0; en = 0;
    tick();
    chk("err_pulse_end", 32'(load_err), 32'h0);
    chk("bad_load_still", 32'(bcd), 32'h25);
    load = 1; load_val = 8'h38;
    tick();
    chk("good_load_38", 32'(bcd), 32'h38);
    chk("good_load_err", 32'(load_err), 32'h0);
    load_val = 8'hA0;
    tick();
    chk("bad_hi_hold", 32'(bcd), 32'h38);
    chk("bad_hi_err", 32'(load_err), 32'h1);

    load_val = 8'h56;
    tick();
    chk("load_56", 32'(bcd), 32'h56);
    clr = 1; load_val = 8'h77; en = 1;
    tick();
    chk("prio_clr", 32'(bcd), 32'h00);
    clr = 0; load_val = 8'h12;
    tick();
    chk("prio_load", 32'(bcd), 32'h12);

    load = 0; clr = 1;
    tick();
    clr = 0; en = 1; up_dn = 1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      chk("sweep_bcd", 32'(bcd), 32'(to_bcd(n % 100)));
      for (int d = 0; d < 2; d++) begin
        dg = bcd[4*d +: 4];
        chk("sweep_valid", 32'(bcd_digit_valid(dg)), 32'h1);
        chk("sweep_xs3", 32'(dg + 4'd3),
            32'(to_bcd(n % 100) >> (4*d) & 8'h0F) + 32'd3);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_up_down_counter.md
Name: bcd_up_down_counter

Overview:
- Synchronous multi-digit BCD up/down counter; the digit source directly upstream of the BCD-to-Excess-3 conversion stage.
- Each 4-bit digit output feeds one converter instance unchanged. Outputs are always legal BCD (0000-1001).
- Supports clear, parallel load with digit validation, count enable and direction.
- Emits a cascade carry/borrow so several instances can be chained.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1-8; digit 0 is least significant.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to all-zero.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  4*DIGITS  load value, digit i at bits [4i+3:4i].
- en  input  1  count enable, one step per enabled cycle.
- up_dn  input  1  1 = count up, 0 = count down.
- bcd  output  4*DIGITS  current count, registered, digit i at [4i+3:4i].
- tc  output  1  terminal count / cascade carry (combinational).
- load_err  output  1  registered one-cycle pulse: rejected load.

Behaviour:
- Reset: asynchronous on rst_n low. All digits become 0000 and load_err becomes 0 immediately, independent of clk. While rst_n is low, all other inputs are ignored. Deassertion takes effect at the next rising edge with no extra wait state.
- Priority at each rising edge: clr > load > en > hold.
- clr=1: all digits become 0. load_err becomes 0.
- load=1 and clr=0:
  - If every digit of load_val is at most 1001: bcd <= load_val, load_err <= 0.
  - If any digit is 1010-1111: the whole load is rejected, bcd holds, and load_err <= 1 for exactly one cycle.
  - A rejected load does not fall through to counting, even when en=1.
- en=1, up_dn=1 (no clr/load): increment by 1 decimal.
  - Digit i steps only when all lower digits are 1001; a stepping digit at 1001 wraps to 0000.
  - All-9s wraps to all-0s.
- en=1, up_dn=0: decrement by 1 decimal.
  - Digit i steps only when all lower digits are 0000; a stepping digit at 0000 wraps to 1001.
  - All-0s wraps to all-9s.
- en=0 (no clr/load): hold. load_err <= 0 on every cycle without a rejected load.
- tc = en AND (up_dn ? all digits 1001 : all digits 0000).
  - Purely combinational from en, up_dn and bcd, so a chained instance can use it as its en in the same cycle.
  - tc ignores clr/load. The system must not drive clr/load in the same cycle it relies on tc.
- Latency: a count, load or clear is visible on bcd one cycle after the sampling edge. A rejected load's load_err is visible one cycle after its edge.
- Digit carry chain: per-digit enable = en AND all lower-digit terminal conditions. No ripple through registers, so the whole count updates in a single edge.
- up_dn may change on any cycle. The new direction applies at the next enabled edge with no pipeline bubble.
- Invalid internal digits (1010-1111) are unreachable. If forced, e.g. by a simulation deposit:
  - Up: the digit recovers to 0000 on its next step.
  - Down: the digit recovers to 1001 on its next step.
  - In either direction the digit does not count as terminal.
- DIGITS=1: tc reduces to that single digit's terminal condition.

Decomposition:
- Shared package/include with:
  - constants BCD_MAX = 4'b1001 and BCD_MIN = 4'b0000;
  - localparam DIGIT_W = 4;
  - a function bcd_digit_valid(4-bit) reused by the converter's test bench.
- One sub-module, bcd_digit_cell: one 4-bit digit register with clr, load, step-enable and up_dn.
  - Outputs: digit value, term_up (digit == 1001), term_dn (digit == 0000).
- Top level: generate-instantiates DIGITS cells, forms the AND-chain of step enables, does load validation and load_err, and drives tc.

Test Plan:
- Reset/hold: assert rst_n=0 mid-count at bcd=0x47 with en=1 -> bcd=0x00 and load_err=0 immediately, without a clock edge. Release with en=0 for 3 cycles -> bcd stays 0x00.
- Up count and wrap (DIGITS=2): load 0x97, then en=1, up_dn=1 for 3 cycles -> bcd 0x98, 0x99, 0x00. tc=1 only during the cycle bcd=0x99.
- Down count and borrow: load 0x10, then en=1, up_dn=0 -> bcd 0x09 after 1 edge. Continue to 0x00 -> tc=1. Next edge -> bcd=0x99.
- Load validation: load_val=0x3A with load=1, en=1 at bcd=0x25 -> bcd stays 0x25 and load_err=1 for one cycle, then 0. Then load_val=0x38 -> bcd=0x38 and load_err=0.
- Priority: clr=1, load=1, en=1 together at bcd=0x56 -> bcd=0x00. Next cycle load=1 with 0x12 and en=1 -> bcd=0x12, with no increment applied.
- Converter integration: every bcd digit of an up-count sweep 0x00-0x99 drives the converter. Each Excess-3 output equals digit+3 (for example 0101 -> 1000), and no digit ever exceeds 1001.
